// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion/render block.
package sprite_pkg;

    localparam int PX_W     = 11;
    localparam int PY_W     = 10;
    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'b000,
        DIR_LEFT  = 3'b001,
        DIR_RIGHT = 3'b010,
        DIR_DOWN  = 3'b011,
        DIR_UP    = 3'b100
    } dir_e;

endpackage

// File: rtl/sprite_dir_fsm.sv
// Direction FSM driven by level buttons, plus the rate divider that paces move ticks.
module sprite_dir_fsm
    import sprite_pkg::*;
#(
    parameter int MOVE_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_left,
    input  logic i_right,
    input  logic i_up,
    input  logic i_down,
    output dir_e o_state,
    output logic o_move_tick
);

    localparam int              DIV_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);

    dir_e             r_state;
    dir_e             w_next;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             r_tick;
    logic             w_tick_next;

    // Next state depends only on the buttons, so any state (even an illegal
    // code) lands on a legal one after a single cycle.
    always_comb begin
        w_next = DIR_IDLE;
        if (i_up)         w_next = DIR_UP;
        else if (i_down)  w_next = DIR_DOWN;
        else if (i_left)  w_next = DIR_LEFT;
        else if (i_right) w_next = DIR_RIGHT;
    end

    always_comb begin
        w_div_next  = '0;
        w_tick_next = 1'b0;
        if (r_state != DIR_IDLE && w_next == r_state) begin
            if (r_div == DIV_LAST) begin
                w_tick_next = 1'b1;
            end else begin
                w_div_next = r_div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DIR_IDLE;
            r_div   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_div   <= w_div_next;
            r_tick  <= w_tick_next;
        end
    end

    assign o_state     = r_state;
    assign o_move_tick = r_tick;

endmodule

// File: rtl/sprite_motion_render.sv
// Moves one sprite from direction buttons and renders it into the pixel stream
// as ROM address / element select / pixel enable, one cycle behind the pixel.
module sprite_motion_render
    import sprite_pkg::*;
#(
    parameter int INIT_X   = 50,
    parameter int INIT_Y   = 300,
    parameter int SIZE_X   = 25,
    parameter int SIZE_Y   = 25,
    parameter int NUM_ELEM = 4,
    parameter int ELEM_SEL = 1,
    parameter int ADDR_W   = 10,
    parameter int OFF_W    = 6,
    parameter int MOVE_DIV = 4,
    parameter int SCREEN_W = sprite_pkg::SCREEN_W,
    parameter int SCREEN_H = sprite_pkg::SCREEN_H
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_left,
    input  logic                i_right,
    input  logic                i_up,
    input  logic                i_down,
    input  logic [PX_W-1:0]     i_pixel_x,
    input  logic [PY_W-1:0]     i_pixel_y,
    input  logic                i_video_en,
    input  logic [OFF_W-1:0]    i_offset_x,
    input  logic [OFF_W-1:0]    i_offset_y,
    output logic [2:0]          o_state,
    output logic                o_move_tick,
    output logic [PX_W-1:0]     o_pos_x,
    output logic [PY_W-1:0]     o_pos_y,
    output logic                o_enable,
    output logic [ADDR_W-1:0]   o_address,
    output logic [NUM_ELEM-1:0] o_element
);

    localparam logic [PX_W-1:0]     X_MAX    = PX_W'(SCREEN_W - SIZE_X);
    localparam logic [PY_W-1:0]     Y_MAX    = PY_W'(SCREEN_H - SIZE_Y);
    localparam logic [NUM_ELEM-1:0] ELEM_HOT = NUM_ELEM'(1) << ELEM_SEL;

    dir_e              w_state;
    logic              w_move_tick;
    logic [PX_W-1:0]   r_pos_x;
    logic [PY_W-1:0]   r_pos_y;

    sprite_dir_fsm #(
        .MOVE_DIV (MOVE_DIV)
    ) u_dir_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_left      (i_left),
        .i_right     (i_right),
        .i_up        (i_up),
        .i_down      (i_down),
        .o_state     (w_state),
        .o_move_tick (w_move_tick)
    );

    // The tick is registered alongside the state that produced it, so the
    // direction to apply is simply the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos_x <= PX_W'(INIT_X);
            r_pos_y <= PY_W'(INIT_Y);
        end else if (w_move_tick) begin
            unique case (w_state)
                DIR_LEFT:  if (r_pos_x != '0)  r_pos_x <= r_pos_x - PX_W'(1);
                DIR_RIGHT: if (r_pos_x < X_MAX) r_pos_x <= r_pos_x + PX_W'(1);
                DIR_DOWN:  if (r_pos_y < Y_MAX) r_pos_y <= r_pos_y + PY_W'(1);
                DIR_UP:    if (r_pos_y != '0)  r_pos_y <= r_pos_y - PY_W'(1);
                default:   ;
            endcase
        end
    end

    // Box test one bit wider than the coordinates so pos+SIZE cannot wrap.
    logic [PX_W:0]     w_x_lo;
    logic [PX_W:0]     w_x_hi;
    logic [PY_W:0]     w_y_lo;
    logic [PY_W:0]     w_y_hi;
    logic [PX_W:0]     w_px;
    logic [PY_W:0]     w_py;
    logic              w_hit;
    logic [PX_W-1:0]   w_lx;
    logic [PY_W-1:0]   w_ly;
    logic [ADDR_W-1:0] w_addr;

    assign w_px   = {1'b0, i_pixel_x};
    assign w_py   = {1'b0, i_pixel_y};
    assign w_x_lo = {1'b0, r_pos_x};
    assign w_y_lo = {1'b0, r_pos_y};
    assign w_x_hi = w_x_lo + (PX_W+1)'(SIZE_X);
    assign w_y_hi = w_y_lo + (PY_W+1)'(SIZE_Y);

    assign w_hit = i_video_en
                && (w_px >= w_x_lo) && (w_px < w_x_hi)
                && (w_py >= w_y_lo) && (w_py < w_y_hi);

    assign w_lx = i_pixel_x - r_pos_x;
    assign w_ly = i_pixel_y - r_pos_y;

    // Offsets select an animation frame laid out in the same ROM; the
    // address wraps modulo the ROM size by truncation.
    assign w_addr = ADDR_W'((32'(w_ly) + 32'(i_offset_y)) * 32'(SIZE_X)
                          + 32'(w_lx) + 32'(i_offset_x));

    always_ff @(posedge clk) begin
        if (reset) begin
            o_enable  <= 1'b0;
            o_address <= '0;
            o_element <= '0;
        end else begin
            o_enable  <= w_hit;
            o_address <= w_hit ? w_addr   : '0;
            o_element <= w_hit ? ELEM_HOT : '0;
        end
    end

    assign o_state     = w_state;
    assign o_move_tick = w_move_tick;
    assign o_pos_x     = r_pos_x;
    assign o_pos_y     = r_pos_y;

endmodule

// File: tb/tb_sprite_motion_render.sv
// Scoreboard bench: a cycle model predicts every registered output per clock.
module tb_sprite_motion_render;

    localparam int INIT_X   = 50;
    localparam int INIT_Y   = 300;
    localparam int SIZE_X   = 25;
    localparam int SIZE_Y   = 25;
    localparam int MOVE_DIV = 4;
    localparam int X_MAX    = 800 - 25;
    localparam int Y_MAX    = 600 - 25;
    localparam logic [3:0] ELEM = 4'b0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_left = 0, i_right = 0, i_up = 0, i_down = 0;
    logic [10:0] i_pixel_x = '0;
    logic [9:0]  i_pixel_y = '0;
    logic        i_video_en = 1'b0;
    logic [5:0]  i_offset_x = '0, i_offset_y = '0;
    logic [2:0]  o_state;
    logic        o_move_tick;
    logic [10:0] o_pos_x;
    logic [9:0]  o_pos_y;
    logic        o_enable;
    logic [9:0]  o_address;
    logic [3:0]  o_element;

    sprite_motion_render dut (
        .clk(clk), .reset(reset),
        .i_left(i_left), .i_right(i_right), .i_up(i_up), .i_down(i_down),
        .i_pixel_x(i_pixel_x), .i_pixel_y(i_pixel_y), .i_video_en(i_video_en),
        .i_offset_x(i_offset_x), .i_offset_y(i_offset_y),
        .o_state(o_state), .o_move_tick(o_move_tick),
        .o_pos_x(o_pos_x), .o_pos_y(o_pos_y),
        .o_enable(o_enable), .o_address(o_address), .o_element(o_element)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int tk; int x; int y; int en; int addr; int el;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;
    int m_state = 0, m_run = 0, m_tick = 0, m_x = INIT_X, m_y = INIT_Y;
    int ticks;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Predict the outputs after the next edge, push, clock, then pop and compare.
    task automatic step();
        exp_t e;
        int nxt, px, py, lx, ly, nx, ny, nrun, ntick;
        bit hit;
        nxt = i_up ? 4 : i_down ? 3 : i_left ? 1 : i_right ? 2 : 0;
        px = int'(i_pixel_x);
        py = int'(i_pixel_y);
        if (reset) begin
            m_state = 0; m_run = 0; m_tick = 0; m_x = INIT_X; m_y = INIT_Y;
            e = '{0, 0, INIT_X, INIT_Y, 0, 0, 0};
        end else begin
            hit = i_video_en && px >= m_x && px < m_x + SIZE_X && py >= m_y && py < m_y + SIZE_Y;
            lx = px - m_x;
            ly = py - m_y;
            nx = m_x;
            ny = m_y;
            if (m_tick != 0) begin
                case (m_state)
                    1: if (m_x > 0) nx = m_x - 1;
                    2: if (m_x < X_MAX) nx = m_x + 1;
                    3: if (m_y < Y_MAX) ny = m_y + 1;
                    4: if (m_y > 0) ny = m_y - 1;
                    default: ;
                endcase
            end
            nrun  = (nxt == m_state && nxt != 0) ? m_run + 1 : 0;
            ntick = (nrun != 0 && nrun % MOVE_DIV == 0) ? 1 : 0;
            m_state = nxt; m_run = nrun; m_tick = ntick; m_x = nx; m_y = ny;
            e.st = nxt; e.tk = ntick; e.x = nx; e.y = ny;
            e.en   = hit ? 1 : 0;
            e.addr = hit ? ((ly + int'(i_offset_y)) * SIZE_X + lx + int'(i_offset_x)) % 1024 : 0;
            e.el   = hit ? int'(ELEM) : 0;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("state", 32'(o_state), e.st);
        chk("move_tick", 32'(o_move_tick), e.tk);
        chk("pos_x", 32'(o_pos_x), e.x);
        chk("pos_y", 32'(o_pos_y), e.y);
        chk("enable", 32'(o_enable), e.en);
        chk("address", 32'(o_address), e.addr);
        chk("element", 32'(o_element), e.el);
    endtask

    task automatic pix(input int x, input int y, input logic ve);
        i_pixel_x  = 11'(x);
        i_pixel_y  = 10'(y);
        i_video_en = ve;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) step();
        chk("rst_state", 32'(o_state), 0);
        chk("rst_pos_x", 32'(o_pos_x), INIT_X);
        chk("rst_pos_y", 32'(o_pos_y), INIT_Y);
        chk("rst_enable", 32'(o_enable), 0);
        reset = 1'b0;

        // top-left corner of the sprite at init position
        pix(50, 300, 1'b1);
        step();
        chk("tl_en", 32'(o_enable), 1);
        chk("tl_addr", 32'(o_address), 0);
        chk("tl_elem", 32'(o_element), 32'(ELEM));

        // hold down: four ticks, y advances by four
        ticks = 0;
        i_down = 1'b1;
        repeat (4 * MOVE_DIV + 1) begin step(); ticks += int'(o_move_tick); end
        chk("down_state", 32'(o_state), 3);
        i_down = 1'b0;
        repeat (2) step();
        chk("down_ticks", 32'(ticks), 4);
        chk("down_y", 32'(o_pos_y), 304);
        chk("down_x", 32'(o_pos_x), 50);

        // up beats left
        i_up = 1'b1; i_left = 1'b1;
        repeat (4 * MOVE_DIV + 1) step();
        chk("upl_state", 32'(o_state), 4);
        chk("upl_x", 32'(o_pos_x), 50);
        chk("upl_y", 32'(o_pos_y), 301);
        i_up = 1'b0; i_left = 1'b0;
        step();
        chk("rel_state", 32'(o_state), 0);

        // fresh press after release: first tick exactly MOVE_DIV cycles later
        i_right = 1'b1;
        repeat (MOVE_DIV) step();
        chk("first_tick_early", 32'(o_move_tick), 0);
        step();
        chk("first_tick", 32'(o_move_tick), 1);
        i_right = 1'b0;
        step();
        reset = 1'b1; step(); reset = 1'b0;

        // box edges and video gating at (50,300)
        pix(74, 324, 1'b1); step();
        chk("br_en", 32'(o_enable), 1);
        chk("br_addr", 32'(o_address), 624);
        pix(75, 300, 1'b1); step();
        chk("right_en", 32'(o_enable), 0);
        chk("right_addr", 32'(o_address), 0);
        chk("right_elem", 32'(o_element), 0);
        pix(74, 324, 1'b0); step();
        chk("blank_en", 32'(o_enable), 0);
        i_offset_x = 6'd25;
        pix(50, 300, 1'b1); step();
        chk("offx_addr", 32'(o_address), 25);
        i_offset_x = '0;

        // saturate at the top-left corner
        i_up = 1'b1;
        repeat (310 * MOVE_DIV) step();
        i_up = 1'b0; i_left = 1'b1;
        repeat (60 * MOVE_DIV) step();
        i_up = 1'b1;
        repeat (3 * MOVE_DIV) step();
        i_up = 1'b0;
        repeat (3 * MOVE_DIV) step();
        chk("min_x", 32'(o_pos_x), 0);
        chk("min_y", 32'(o_pos_y), 0);
        i_left = 1'b0;

        // saturate at the bottom-right corner
        i_down = 1'b1;
        repeat (600 * MOVE_DIV) step();
        i_down = 1'b0; i_right = 1'b1;
        repeat (800 * MOVE_DIV) step();
        i_right = 1'b0;
        step();
        chk("max_x", 32'(o_pos_x), X_MAX);
        chk("max_y", 32'(o_pos_y), Y_MAX);

        // reach (60,310), then reset while a tick is pending
        reset = 1'b1; step(); reset = 1'b0;
        i_down = 1'b1; repeat (10 * MOVE_DIV + 1) step(); i_down = 1'b0; step();
        i_right = 1'b1; repeat (10 * MOVE_DIV + 1) step(); i_right = 1'b0; step();
        chk("mid_x", 32'(o_pos_x), 60);
        chk("mid_y", 32'(o_pos_y), 310);
        i_right = 1'b1;
        repeat (MOVE_DIV + 1) step();
        chk("mid_tick", 32'(o_move_tick), 1);
        reset = 1'b1; step();
        chk("rstmv_x", 32'(o_pos_x), INIT_X);
        chk("rstmv_y", 32'(o_pos_y), INIT_Y);
        chk("rstmv_state", 32'(o_state), 0);
        chk("rstmv_tick", 32'(o_move_tick), 0);
        reset = 1'b0; i_right = 1'b0;

        // random buttons and pixels around the sprite
        for (int i = 0; i < 400; i++) begin
            int rx, ry;
            {i_up, i_down, i_left, i_right} = 4'($urandom_range(0, 15));
            rx = m_x + int'($urandom_range(0, SIZE_X + 3)) - 2;
            ry = m_y + int'($urandom_range(0, SIZE_Y + 3)) - 2;
            if (rx < 0) rx = 0;
            if (ry < 0) ry = 0;
            pix(rx, ry, 1'($urandom_range(0, 3) != 0));
            i_offset_x = 6'($urandom_range(0, 63));
            i_offset_y = 6'($urandom_range(0, 63));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
